// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package adder_seq_pkg;

    // Width of the single adder slice reused on every RUN cycle.
    localparam int NIBBLE_W = 4;

    // Sequencer states: waiting for operands, stepping nibbles, holding result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : adder_seq_pkg

// File: rtl/adder_seq_ctrl_nibble_add.sv
// nibble_add: combinational 4-bit ripple-carry adder slice. This is the only
// adder in the sequencer; it is time-shared across all nibbles of an operand.
module nibble_add
    import adder_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic c;

    // Ripple the carry bit by bit; the carry is the full-adder majority function.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so the carry chain updates
        // in order within one evaluation; every output gets a default first so
        // no latch is inferred.
        sum = '0;
        c   = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule : nibble_add

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: multi-cycle WIDTH-bit adder that reuses one nibble_add slice,
// processing one nibble per clock, LSB first, with a registered inter-nibble
// carry. Operands arrive on a valid/ready handshake and the result leaves on
// another; a result is ready exactly WIDTH/4 cycles after acceptance.
// WIDTH must be a multiple of 4 and at least 8.
// Build option: define ADDSEQ_SUB_EN to add the in_sub port; a latched in_sub
// inverts B at capture and forces carry-in to 1 (out_cout=1 then means no borrow).
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADDSEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [WIDTH-1:0]    b_cap;
    logic                cin_cap;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;

    // Operand B and carry-in as they are captured on acceptance.
`ifdef ADDSEQ_SUB_EN
    assign b_cap   = in_sub ? ~in_b : in_b;
    assign cin_cap = in_sub | in_cin;
`else
    assign b_cap   = in_b;
    assign cin_cap = in_cin;
`endif

    // The shared adder always looks at the low nibble of the shifting operands.
    nibble_add u_nibble_add (
        .a    (a_q[NIBBLE_W-1:0]),
        .b    (b_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Sequencer FSM plus datapath registers: capture, shift-and-add, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, so out_sum/out_cout
            // read zero after reset instead of stale or X values.
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // in_ready is high in IDLE, so in_valid alone completes the handshake.
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= b_cap;
                        carry_q <= cin_cap;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // New sum nibble enters at the top; after NIBBLES steps the
                    // first nibble computed has reached bit 0.
                    a_q     <= a_q >> NIBBLE_W;
                    b_q     <= b_q >> NIBBLE_W;
                    sum_q   <= {nib_sum, sum_q[WIDTH-1:NIBBLE_W]};
                    carry_q <= nib_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result and carry are frozen until the consumer takes them.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

endmodule : adder_seq_ctrl
